date_counter: RTL
=================

Name: date_counter

Overview:
- Calendar stage directly downstream of the hours counter. It consumes the hours counter's one-cycle `done_hour` rollover pulse and maintains day, month and year-of-century.
- It emits a one-cycle `done_century` pulse when the date wraps from 31/12/99 to 01/01/00.
- It shares the hours counter's `display`, `tick` and `inc_dec` controls. The field being edited is selected by `setup_sel`.

Parameters:
- YEAR_MAX, 99, last year value before the century wrap; the year range is 0..YEAR_MAX.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- display  in  1  0 = run mode (advance on done_hour); 1 = setup mode.
- setup_sel  in  2  setup field select: 00 none, 01 day, 10 month, 11 year.
- inc_dec  in  1  setup direction: 1 = increment, 0 = decrement.
- tick  in  1  one-cycle setup step strobe.
- done_hour  in  1  one-cycle pulse from the hours counter on 23→0.
- day  out  5  day of month, 1..31.
- month  out  4  month, 1..12.
- year  out  7  year of century, 0..YEAR_MAX.
- done_century  out  1  registered one-cycle century-wrap pulse.

Behaviour:
- Reset: on a rising edge with rst=0, the outputs become day=1, month=1, year=0, done_century=0.
  - Reset has priority over every other input, including in mid-setup or mid-rollover.
- Days-in-month (dim) is computed combinationally from month and year:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February: 29 if year[1:0]==0, else 28. Year 00 counts as a leap year.
- Run mode (display=0): setup_sel, tick and inc_dec are ignored. A cycle with done_hour=1 performs one day advance:
  - day<dim: day+1.
  - day==dim: day=1, then month steps:
    - month<12: month+1.
    - month==12: month=1, then year steps:
      - year<YEAR_MAX: year+1.
      - year==YEAR_MAX: year=0 and done_century=1.
  - All fields update on the same edge. Latency is 1 clk from the done_hour sample.
- Setup mode (display=1): done_hour is ignored, so a pulse arriving in setup mode is lost. A cycle with tick=1 steps the selected field once:
  - day: inc wraps dim→1; dec wraps 1→dim.
  - month: inc wraps 12→1; dec wraps 1→12.
  - year: inc wraps YEAR_MAX→0; dec wraps 0→YEAR_MAX. done_century is never asserted in setup mode.
  - setup_sel=00, or tick=0: hold all fields.
- Clamp: after a month or year step, if the current day exceeds the new dim, day is loaded with the new dim on the same edge. Example: 31/03 with month decremented gives 28/02 or 29/02.
- done_century:
  - Registered; high for exactly one cycle, on the same edge that year becomes 0.
  - Cleared on the next edge unless a new wrap occurs.
- Invariants: outputs are never outside their ranges, and day never exceeds dim. Values outside the legal range cannot be entered through the ports, so no recovery path is required.
- There is no combinational path from any input to any output.

Test Plan:
- Reset: drive random inputs, assert rst=0 for 2 cycles → day=1, month=1, year=0, done_century=0. Repeat with rst applied mid-setup → same values on the next edge.
- Month rollover:
  - Set 31/01/05, pulse done_hour → 01/02/05.
  - Set 28/02/05, pulse → 01/03/05.
  - Set 28/02/04, pulse → 29/02/04; pulse again → 01/03/04.
- Century wrap: set 31/12/99, display=0, pulse done_hour → 01/01/00. done_century=1 for exactly one cycle, coincident with year=0; the next cycle it is 0.
- Setup wrap:
  - Month 04, day 01, setup_sel=01, inc_dec=0, tick → day=30; inc tick → day=01.
  - Year 00, setup_sel=11, dec tick → year=99 with done_century=0.
- Clamp:
  - Set 31/03/01, setup_sel=10, dec tick → 28/02/01.
  - Set 29/02/04, setup_sel=11, inc tick → 28/02/05.
- Mode isolation:
  - display=1, done_hour pulses → date unchanged.
  - display=0, tick with setup_sel=01 → date unchanged.
  - setup_sel=00 with ticks → unchanged.

Source files
------------

// File: rtl/date_counter_if.sv
// date_counter_if: control inputs and date outputs of the calendar stage.
interface date_counter_if;
   logic       display;
   logic [1:0] setup_sel;
   logic       inc_dec;
   logic       tick;
   logic       done_hour;
   logic [4:0] day;
   logic [3:0] month;
   logic [6:0] year;
   logic       done_century;
   modport master (output display, setup_sel, inc_dec, tick, done_hour,
                   input  day, month, year, done_century);
   modport slave  (input  display, setup_sel, inc_dec, tick, done_hour,
                   output day, month, year, done_century);
endinterface

// File: rtl/date_counter.sv
// date_counter: day/month/year-of-century calendar advanced by done_hour, editable in setup mode.
module date_counter #(
   parameter int unsigned YEAR_MAX = 99
) (
   input logic          clk,
   input logic          rst,
   date_counter_if.slave bus
);
   localparam logic [6:0] YMAX = 7'(YEAR_MAX);
   logic [4:0] day_q, day_d, dim_c, dim_n;
   logic [3:0] month_q, month_d;
   logic [6:0] year_q, year_d;
   logic       cent_q, cent_d;
   function automatic logic [4:0] dim(input logic [3:0] m, input logic [6:0] y);
      return (m == 4'd2) ? ((y[1:0] == 2'd0) ? 5'd29 : 5'd28) :
             (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
   endfunction
   always_comb begin
      dim_c   = dim(month_q, year_q);
      day_d   = day_q;
      month_d = month_q;
      year_d  = year_q;
      cent_d  = 1'b0;
      if (!bus.display && bus.done_hour) begin
         day_d = (day_q >= dim_c) ? 5'd1 : day_q + 5'd1;
         if (day_q >= dim_c) begin
            month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
            if (month_q >= 4'd12) begin
               year_d = (year_q >= YMAX) ? 7'd0 : year_q + 7'd1;
               cent_d = (year_q >= YMAX);
            end
         end
      end else if (bus.display && bus.tick) begin
         case (bus.setup_sel)
            2'b01: day_d = bus.inc_dec ? ((day_q >= dim_c) ? 5'd1 : day_q + 5'd1)
                                       : ((day_q <= 5'd1) ? dim_c : day_q - 5'd1);
            2'b10: month_d = bus.inc_dec ? ((month_q >= 4'd12) ? 4'd1 : month_q + 4'd1)
                                         : ((month_q <= 4'd1) ? 4'd12 : month_q - 4'd1);
            2'b11: year_d = bus.inc_dec ? ((year_q >= YMAX) ? 7'd0 : year_q + 7'd1)
                                        : ((year_q == 7'd0) ? YMAX : year_q - 7'd1);
            default: ;
         endcase
      end
      // keep day legal when the month or year change shortens the month
      dim_n = dim(month_d, year_d);
      if (day_d > dim_n) day_d = dim_n;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         day_q   <= 5'd1;
         month_q <= 4'd1;
         year_q  <= 7'd0;
         cent_q  <= 1'b0;
      end else begin
         day_q   <= day_d;
         month_q <= month_d;
         year_q  <= year_d;
         cent_q  <= cent_d;
      end
   end
   assign bus.day          = day_q;
   assign bus.month        = month_q;
   assign bus.year         = year_q;
   assign bus.done_century = cent_q;
endmodule
